// File: rtl/data_mem_ws_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : data_mem_ws_if
// Brief    : Request/response bus between a master and the wait-state memory.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface data_mem_ws_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     rdata;
    logic                  ack;
    logic                  err;
    logic                  busy;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ws.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : data_mem_ws
// Brief    : Single-port data memory with programmable wait states, byte
//            enables and alignment/range error reporting.
// Revision : 1.0
// ---------------------------------------------------------------------------
module data_mem_ws #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    data_mem_ws_if.slave    bus
);
    localparam int c_BYTES = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_BYTES);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_TOP_W = c_OFF_W + c_IDX_W;

    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [DATA_W-1:0] DM [DEPTH];

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_BYTES-1:0] r_be;

    logic               w_resp;
    logic               w_misaligned;
    logic               w_oor;
    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_be    <= bus.be;
                        if (LATENCY == 0) begin
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_LAT_M1;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    generate
        if (c_OFF_W > 0) begin : g_off
            assign w_misaligned = |r_addr[c_OFF_W-1:0];
        end else begin : g_no_off
            assign w_misaligned = 1'b0;
        end

        // Any address bit above the word index means the word lies past DEPTH.
        if (ADDR_W > c_TOP_W) begin : g_range
            assign w_oor = |r_addr[ADDR_W-1:c_TOP_W];
        end else begin : g_no_range
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_idx  = r_addr[c_OFF_W +: c_IDX_W];
    assign w_resp = (r_state == c_RESP);
    assign w_err  = w_misaligned | w_oor;

    assign bus.ack   = w_resp;
    assign bus.err   = w_resp & w_err;
    assign bus.busy  = (r_state != c_IDLE);
    assign bus.rdata = (w_resp && !r_we && !w_err) ? DM[w_idx] : '0;

    // Write lands on the edge that closes the response cycle; a reset on that
    // same edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && w_resp && r_we && !w_err) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (r_be[b]) begin
                    DM[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_ws.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_data_mem_ws
// Brief    : Directed self-checking bench for data_mem_ws (LATENCY 2 and 0).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_data_mem_ws;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_ws_if #(.DATA_W(64), .ADDR_W(64)) m  ();
    data_mem_ws_if #(.DATA_W(64), .ADDR_W(64)) m0 ();

    data_mem_ws #(.DATA_W(64), .ADDR_W(64), .DEPTH(1024), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    data_mem_ws #(.DATA_W(64), .ADDR_W(64), .DEPTH(1024), .LATENCY(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (m0.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits (bounded) for its ack; returns the number of
    // cycles from the request cycle to the ack cycle, or -1 on timeout.
    task automatic access(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] b, output int lat,
                          output logic [63:0] rd, output logic e);
        m.req = 1'b1; m.we = w; m.addr = a; m.wdata = d; m.be = b;
        lat = -1; rd = '0; e = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            m.req = 1'b0;
            if (m.ack) begin
                lat = i; rd = m.rdata; e = m.err;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m.req = 1'b1; m.we = 1'b0; m.addr = 64'd32; m.wdata = '0; m.be = '0;
        m0.req = 1'b0; m0.we = 1'b0; m0.addr = '0; m0.wdata = '0; m0.be = '0;
        tick(); tick();
        checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", m.busy); end
        checks++; if (m.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", m.ack); end
        checks++; if (m.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", m.err); end
        checks++; if (m.rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", m.rdata); end
        m.req = 1'b0;
        rst = 1'b0;
        tick();
        checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after: got %b expected 0", m.busy); end
    endtask

    task automatic test_read_timing();
        dut.DM[4] = 64'h1122334455667788;
        m.req = 1'b1; m.we = 1'b0; m.addr = 64'd32; m.be = 8'h00;
        tick(); m.req = 1'b0;   // cycle k+1
        checks++; if ({m.busy, m.ack} !== 2'b10) begin errors++; $display("FAIL rd_k1 busy/ack: got %b expected 10", {m.busy, m.ack}); end
        tick();                 // cycle k+2
        checks++; if ({m.busy, m.ack} !== 2'b10) begin errors++; $display("FAIL rd_k2 busy/ack: got %b expected 10", {m.busy, m.ack}); end
        checks++; if (m.rdata !== 64'd0) begin errors++; $display("FAIL rd_k2_rdata: got %h expected 0", m.rdata); end
        tick();                 // cycle k+3
        checks++; if ({m.busy, m.ack, m.err} !== 3'b110) begin errors++; $display("FAIL rd_k3 busy/ack/err: got %b expected 110", {m.busy, m.ack, m.err}); end
        checks++; if (m.rdata !== 64'h1122334455667788) begin errors++; $display("FAIL rd_k3_rdata: got %h expected 1122334455667788", m.rdata); end
        tick();                 // cycle k+4
        checks++; if ({m.busy, m.ack, m.err} !== 3'b000) begin errors++; $display("FAIL rd_k4 busy/ack/err: got %b expected 000", {m.busy, m.ack, m.err}); end
        checks++; if (m.rdata !== 64'd0) begin errors++; $display("FAIL rd_k4_rdata: got %h expected 0", m.rdata); end
    endtask

    task automatic test_byte_write();
        int lat; logic [63:0] rd; logic e;
        access(1'b1, 64'd32, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
        access(1'b0, 64'd32, 64'd0, 8'h00, lat, rd, e);
        checks++; if (rd !== 64'h11223344FFFFFFFF) begin errors++; $display("FAIL wr_lo_readback: got %h expected 11223344ffffffff", rd); end
        access(1'b1, 64'd32, 64'hAABBCCDDEEFF0011, 8'hC0, lat, rd, e);
        access(1'b0, 64'd32, 64'd0, 8'h00, lat, rd, e);
        checks++; if (rd !== 64'hAABB3344FFFFFFFF) begin errors++; $display("FAIL wr_hi_readback: got %h expected aabb3344ffffffff", rd); end
        access(1'b1, 64'd32, 64'h0, 8'h00, lat, rd, e);
        checks++; if ({lat == 3, e} !== 2'b10) begin errors++; $display("FAIL wr_be0 lat/err: got lat=%0d err=%b expected lat=3 err=0", lat, e); end
        checks++; if (dut.DM[4] !== 64'hAABB3344FFFFFFFF) begin errors++; $display("FAIL wr_be0_unchanged: got %h expected aabb3344ffffffff", dut.DM[4]); end
    endtask

    task automatic test_errors();
        int lat; logic [63:0] rd; logic e;
        dut.DM[0]    = 64'h0123456789ABCDEF;
        dut.DM[1023] = 64'hCAFEF00DDEADBEEF;
        access(1'b0, 64'd33, 64'd0, 8'h00, lat, rd, e);
        checks++; if ({lat == 3, e} !== 2'b11) begin errors++; $display("FAIL misaligned lat/err: got lat=%0d err=%b expected lat=3 err=1", lat, e); end
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL misaligned_rdata: got %h expected 0", rd); end
        access(1'b1, 64'd8192, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, rd, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected 1", e); end
        checks++; if (dut.DM[0] !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL oor_write_dm0: got %h expected 0123456789abcdef", dut.DM[0]); end
        access(1'b1, 64'd36, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, rd, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_write_err: got %b expected 1", e); end
        checks++; if (dut.DM[4] !== 64'hAABB3344FFFFFFFF) begin errors++; $display("FAIL misaligned_write_dm4: got %h expected aabb3344ffffffff", dut.DM[4]); end
        access(1'b0, 64'd8184, 64'd0, 8'h00, lat, rd, e);
        checks++; if ({e, rd} !== {1'b0, 64'hCAFEF00DDEADBEEF}) begin errors++; $display("FAIL last_word_read: got err=%b rdata=%h expected err=0 rdata=cafef00ddeadbeef", e, rd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] acks = '0;
        m.req = 1'b1; m.we = 1'b0; m.addr = 64'd32; m.be = 8'h00;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c >= 12) m.req = 1'b0;
            acks[c] = m.ack;
        end
        m.req = 1'b0;
        checks++; if (acks !== 16'h0888) begin errors++; $display("FAIL back_to_back_acks: got %h expected 0888", acks); end
    endtask

    task automatic test_reset_in_wait();
        logic seen_ack = 1'b0;
        dut.DM[8] = 64'h5555_AAAA_5555_AAAA;
        m.req = 1'b1; m.we = 1'b1; m.addr = 64'd64; m.wdata = 64'h0; m.be = 8'hFF;
        tick(); m.req = 1'b0;   // in WAIT
        checks++; if (m.busy !== 1'b1) begin errors++; $display("FAIL rstwait_busy_before: got %b expected 1", m.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({m.busy, m.ack} !== 2'b00) begin errors++; $display("FAIL rstwait_after busy/ack: got %b expected 00", {m.busy, m.ack}); end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (m.ack) seen_ack = 1'b1;
        end
        checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL rstwait_no_ack: got %b expected 0", seen_ack); end
        checks++; if (dut.DM[8] !== 64'h5555_AAAA_5555_AAAA) begin errors++; $display("FAIL rstwait_dm: got %h expected 5555aaaa5555aaaa", dut.DM[8]); end
    endtask

    task automatic test_latency0();
        dut0.DM[2] = 64'hDEAD_BEEF_0BAD_F00D;
        m0.req = 1'b1; m0.we = 1'b0; m0.addr = 64'd16; m0.be = 8'h00;
        tick(); m0.req = 1'b0;  // cycle k+1
        checks++; if ({m0.ack, m0.busy, m0.err} !== 3'b110) begin errors++; $display("FAIL lat0_k1 ack/busy/err: got %b expected 110", {m0.ack, m0.busy, m0.err}); end
        checks++; if (m0.rdata !== 64'hDEAD_BEEF_0BAD_F00D) begin errors++; $display("FAIL lat0_rdata: got %h expected deadbeef0badf00d", m0.rdata); end
        tick();
        checks++; if ({m0.ack, m0.busy} !== 2'b00) begin errors++; $display("FAIL lat0_k2 ack/busy: got %b expected 00", {m0.ack, m0.busy}); end
    endtask

    initial begin
        test_reset();
        test_read_timing();
        test_byte_write();
        test_errors();
        test_back_to_back();
        test_reset_in_wait();
        test_latency0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
